// File: rtl/carregador_matrizes.sv
// Upstream loader for the matrix ALU: fetches two 5x5 byte matrices from a synchronous RAM,
// packs them into 200-bit buses and runs the ALU start/done handshake with an optional timeout.
module carregador_matrizes #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [199:0]      matrizA,
  output logic [199:0]      matrizB,
  output logic [3:0]        opcode,
  output logic              start,
  input  logic              done,
  output logic              op_done,
  output logic              error
);

  localparam int         TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [4:0] LAST_K = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_DRAIN  = 3'd3,
    S_RUN    = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              mem_rd_en_q;
  logic              start_q;
  logic              op_done_q;
  logic              error_q;
  logic              need_b_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        opcode_q;
  logic [4:0]        k_q;
  logic [199:0]      mat_a_q;
  logic [199:0]      mat_b_q;
  logic              cap_vld_q;
  logic              cap_b_q;
  logic [4:0]        cap_idx_q;
  logic [TMO_W-1:0]  tmo_q;

  logic [4:0]        k_d;
  logic [ADDR_W-1:0] addr_a_d;
  logic [ADDR_W-1:0] addr_b_d;
  logic              need_b_d;
  logic              tmo_hit_s;

  // Next read address, B-operand decode and timeout detection
  always_comb begin
    k_d       = k_q + 5'd1;
    addr_a_d  = base_a_q + ADDR_W'(k_d);
    addr_b_d  = base_b_q + ADDR_W'(k_d);
    need_b_d  = (cmd_opcode == 4'b0011) || (cmd_opcode == 4'b0100) || (cmd_opcode == 4'b0101);
    tmo_hit_s = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  end

  // Control FSM, read sequencing, delayed byte capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      start_q     <= 1'b0;
      op_done_q   <= 1'b0;
      error_q     <= 1'b0;
      need_b_q    <= 1'b0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      mem_addr_q  <= '0;
      opcode_q    <= 4'd0;
      k_q         <= 5'd0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      cap_vld_q   <= 1'b0;
      cap_b_q     <= 1'b0;
      cap_idx_q   <= 5'd0;
      tmo_q       <= '0;
    end else begin
      // read data arrives one cycle after issue, so index/target trail the issuing state
      if (cap_vld_q) begin
        if (cap_b_q) begin
          mat_b_q[{cap_idx_q, 3'b000} +: 8] <= mem_rd_data;
        end else begin
          mat_a_q[{cap_idx_q, 3'b000} +: 8] <= mem_rd_data;
        end
      end
      cap_vld_q <= mem_rd_en_q;
      cap_idx_q <= k_q;
      cap_b_q   <= (state_q == S_LOAD_B);

      case (state_q)
        S_IDLE: begin
          op_done_q   <= 1'b0;
          error_q     <= 1'b0;
          start_q     <= 1'b0;
          mem_rd_en_q <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            opcode_q    <= cmd_opcode;
            base_a_q    <= cmd_addr_a;
            base_b_q    <= cmd_addr_b;
            need_b_q    <= need_b_d;
            mat_b_q     <= '0;
            k_q         <= 5'd0;
            mem_addr_q  <= cmd_addr_a;
            mem_rd_en_q <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_LOAD_A;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (k_q == LAST_K) begin
            k_q <= 5'd0;
            if (need_b_q) begin
              mem_addr_q <= base_b_q;
              state_q    <= S_LOAD_B;
            end else begin
              mem_rd_en_q <= 1'b0;
              state_q     <= S_DRAIN;
            end
          end else begin
            k_q        <= k_d;
            mem_addr_q <= addr_a_d;
          end
        end
        S_LOAD_B: begin
          if (k_q == LAST_K) begin
            k_q         <= 5'd0;
            mem_rd_en_q <= 1'b0;
            state_q     <= S_DRAIN;
          end else begin
            k_q        <= k_d;
            mem_addr_q <= addr_b_d;
          end
        end
        S_DRAIN: begin
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (done) begin
            start_q   <= 1'b0;
            op_done_q <= 1'b1;
            error_q   <= 1'b0;
            state_q   <= S_FINISH;
          end else if (tmo_hit_s) begin
            start_q   <= 1'b0;
            op_done_q <= 1'b1;
            error_q   <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_FINISH: begin
          op_done_q   <= 1'b0;
          error_q     <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          start_q     <= 1'b0;
          mem_rd_en_q <= 1'b0;
          op_done_q   <= 1'b0;
          error_q     <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign matrizA   = mat_a_q;
  assign matrizB   = mat_b_q;
  assign opcode    = opcode_q;
  assign start     = start_q;
  assign op_done   = op_done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_carregador_matrizes.sv
// Scoreboard bench for carregador_matrizes: default instance plus a TIMEOUT=16 instance,
// observed through one shared monitor selected by sel.
module tb_carregador_matrizes;

  typedef struct {
    logic [199:0] a;
    logic [199:0] b;
    logic [3:0]   op;
    logic         err;
    int           lat;
    int           run;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic cmd_valid = 1'b0;
  logic [3:0] cmd_opcode = 4'd0;
  logic [7:0] cmd_addr_a = 8'd0;
  logic [7:0] cmd_addr_b = 8'd0;

  logic cv1, cv2;
  logic cmd_ready1, rd_en1, start1, op_done1, err1;
  logic cmd_ready2, rd_en2, start2, op_done2, err2;
  logic [7:0] addr1, addr2;
  logic [7:0] rd_data1 = 8'd0;
  logic [7:0] rd_data2 = 8'd0;
  logic [199:0] ma1, mb1, ma2, mb2;
  logic [3:0] op1, op2;
  logic done1 = 1'b0;
  logic done2;

  logic [7:0] mem [256];
  int alu_d = 1;
  int acnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int run_cnt = 0;
  logic start_prev = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] addr_q[$];
  exp_t sb_q[$];

  assign cv1   = cmd_valid & ~sel;
  assign cv2   = cmd_valid & sel;
  assign done2 = 1'b0;

  logic m_ready, m_rd_en, m_start, m_op_done, m_err;
  logic [7:0] m_addr;
  logic [199:0] m_a, m_b;
  logic [3:0] m_op;
  assign m_ready   = sel ? cmd_ready2 : cmd_ready1;
  assign m_rd_en   = sel ? rd_en2 : rd_en1;
  assign m_addr    = sel ? addr2 : addr1;
  assign m_start   = sel ? start2 : start1;
  assign m_op_done = sel ? op_done2 : op_done1;
  assign m_err     = sel ? err2 : err1;
  assign m_a       = sel ? ma2 : ma1;
  assign m_b       = sel ? mb2 : mb1;
  assign m_op      = sel ? op2 : op1;

  carregador_matrizes dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cmd_ready1),
    .cmd_opcode(cmd_opcode), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rd_data1),
    .matrizA(ma1), .matrizB(mb1), .opcode(op1), .start(start1), .done(done1),
    .op_done(op_done1), .error(err1)
  );

  carregador_matrizes #(.ADDR_W(8), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv2), .cmd_ready(cmd_ready2),
    .cmd_opcode(cmd_opcode), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .mem_rd_en(rd_en2), .mem_addr(addr2), .mem_rd_data(rd_data2),
    .matrizA(ma2), .matrizB(mb2), .opcode(op2), .start(start2), .done(done2),
    .op_done(op_done2), .error(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem[addr1];
    if (rd_en2) rd_data2 <= mem[addr2];
  end

  // ALU model: done rises alu_d cycles after start, drops once start falls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done1 <= 1'b0;
      acnt  <= 0;
    end else if (start1) begin
      acnt  <= acnt + 1;
      done1 <= (alu_d != 0) && (acnt + 1 >= alu_d);
    end else begin
      acnt  <= 0;
      done1 <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] expv);
    n_chk = n_chk + 1;
    if (act !== expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_chk = n_chk + 1;
    n_fail = n_fail + 1;
    $display("FAIL %s: %s", name, msg);
  endtask

  // monitor: checks reads, start timing, hold during RUN and completion
  always @(negedge clk) begin
    if (!rst_n) begin
      start_prev = 1'b0;
      run_cnt = 0;
    end else begin
      if (cmd_valid && m_ready) acc_cyc = cyc;
      if (m_rd_en) begin
        if (addr_q.size() == 0) fail("rd_unexpected", $sformatf("read at %0h", m_addr));
        else chk("rd_addr", 200'(m_addr), 200'(addr_q.pop_front()));
      end
      if (m_start && !start_prev) begin
        run_cnt = 0;
        if (sb_q.size() == 0) fail("start_unexpected", "start rose with no command");
        else begin
          chk("start_lat", 200'(cyc - acc_cyc), 200'(sb_q[0].lat));
          chk("matA", m_a, sb_q[0].a);
          chk("matB", m_b, sb_q[0].b);
          chk("opcode", 200'(m_op), 200'(sb_q[0].op));
        end
      end
      if (m_start) begin
        run_cnt = run_cnt + 1;
        chk("run_ready", 200'(m_ready), 200'(1'b0));
        if (sb_q.size() != 0) begin
          chk("run_stable_a", m_a, sb_q[0].a);
          chk("run_stable_op", 200'(m_op), 200'(sb_q[0].op));
        end
      end
      if (m_op_done) begin
        if (sb_q.size() == 0) fail("op_done_unexpected", "no pending command");
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("error", 200'(m_err), 200'(e.err));
          chk("run_len", 200'(run_cnt), 200'(e.run));
          chk("start_low", 200'(m_start), 200'(1'b0));
        end
      end
      start_prev = m_start;
    end
  end

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] ba, input logic [7:0] bb,
                          input int run, input logic err);
    exp_t e;
    logic nb;
    logic [7:0] ad;
    nb = (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0101);
    e.a = '0;
    e.b = '0;
    for (int k = 0; k < 25; k++) begin
      ad = ba + 8'(k);
      addr_q.push_back(ad);
      e.a[8*k +: 8] = mem[ad];
    end
    if (nb) begin
      for (int k = 0; k < 25; k++) begin
        ad = bb + 8'(k);
        addr_q.push_back(ad);
        e.b[8*k +: 8] = mem[ad];
      end
    end
    e.op = op;
    e.err = err;
    e.lat = nb ? 52 : 27;
    e.run = run;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] ba, input logic [7:0] bb);
    int w;
    w = 0;
    while (m_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) fail("cmd_ready_wait", "cmd_ready never rose");
    cmd_opcode = op;
    cmd_addr_a = ba;
    cmd_addr_b = bb;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      fail(name, "no op_done within budget");
      sb_q.delete();
    end
    chk({name, "_reads_left"}, 200'(addr_q.size()), 200'(0));
    addr_q.delete();
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) begin
      if (i < 64) mem[i] = 8'(i);
      else if (i < 128) mem[i] = 8'(2 * (i - 64));
      else mem[i] = 8'(i) ^ 8'h5A;
    end

    // T1a: outputs held at zero while in reset, ready after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 200'(cmd_ready1), 200'(1'b0));
    chk("rst_rd_en", 200'(rd_en1), 200'(1'b0));
    chk("rst_matA", ma1, 200'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", 200'(cmd_ready1), 200'(1'b1));

    // T2: soma
    alu_d = 1;
    push_cmd(4'b0011, 8'h00, 8'h40, 2, 1'b0);
    send(4'b0011, 8'h00, 8'h40);
    wait_idle("T2", 200);
    chk("T2_a_lo", 200'(ma1[7:0]), 200'(8'd0));
    chk("T2_a_hi", 200'(ma1[199:192]), 200'(8'd24));
    chk("T2_b_hi", 200'(mb1[199:192]), 200'(8'd48));
    chk("T2_b_e1", 200'(mb1[15:8]), 200'(8'd2));

    // T3: transposta with address wrap; B must be cleared
    alu_d = 3;
    push_cmd(4'b0110, 8'hF0, 8'h40, 4, 1'b0);
    send(4'b0110, 8'hF0, 8'h40);
    wait_idle("T3", 200);
    chk("T3_b_zero", mb1, 200'd0);
    chk("T3_a_e15", 200'(ma1[127:120]), 200'(8'hA5));
    chk("T3_a_e16", 200'(ma1[135:128]), 200'(8'h00));
    chk("T3_a_e24", 200'(ma1[199:192]), 200'(8'h08));

    // T4: mult with slow ALU; commands offered during RUN are ignored
    alu_d = 40;
    push_cmd(4'b0101, 8'h10, 8'h80, 41, 1'b0);
    send(4'b0101, 8'h10, 8'h80);
    w = 0;
    while (start1 !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) fail("T4_start_wait", "start never rose");
    repeat (5) @(posedge clk);
    #1;
    cmd_opcode = 4'b0011;
    cmd_addr_a = 8'h00;
    cmd_addr_b = 8'h00;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("T4_busy_ready", 200'(cmd_ready1), 200'(1'b0));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle("T4", 200);
    chk("T4_op_hold", 200'(op1), 200'(4'b0101));

    // T5: TIMEOUT=16 instance, ALU never answers; a second command still runs
    sel = 1'b1;
    push_cmd(4'b0011, 8'h00, 8'h40, 16, 1'b1);
    send(4'b0011, 8'h00, 8'h40);
    wait_idle("T5a", 200);
    push_cmd(4'b0111, 8'h20, 8'h00, 16, 1'b1);
    send(4'b0111, 8'h20, 8'h00);
    wait_idle("T5b", 200);
    sel = 1'b0;
    @(posedge clk); #1;

    // T6/T1: asynchronous reset in the middle of LOAD_B
    alu_d = 1;
    push_cmd(4'b0011, 8'h00, 8'h40, 2, 1'b0);
    send(4'b0011, 8'h00, 8'h40);
    w = 0;
    while (addr_q.size() > 15 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) fail("T6_wait", "reads did not progress");
    #1;
    rst_n = 1'b0;
    #1;
    chk("T6_rd_en", 200'(rd_en1), 200'(1'b0));
    chk("T6_start", 200'(start1), 200'(1'b0));
    chk("T6_ready", 200'(cmd_ready1), 200'(1'b0));
    chk("T6_addr", 200'(addr1), 200'(8'd0));
    chk("T6_matA", ma1, 200'd0);
    chk("T6_matB", mb1, 200'd0);
    chk("T6_op", 200'(op1), 200'(4'd0));
    chk("T6_flags", 200'({op_done1, err1}), 200'(2'b00));
    sb_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_cmd(4'b0011, 8'h00, 8'h40, 2, 1'b0);
    send(4'b0011, 8'h00, 8'h40);
    wait_idle("T6", 200);
    chk("T6_a_hi", 200'(ma1[199:192]), 200'(8'd24));
    chk("T6_b_hi", 200'(mb1[199:192]), 200'(8'd48));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
